// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: sequencing FSM states, register address
// width and the NOP/bubble encodings loaded by the stage registers.
package pipe_pkg;

    // Hazard controller FSM states
    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_e;

    // Register file address width
    localparam int REG_AW = 5;

    // Width of the multi-cycle down-counter
    localparam int MC_CNT_W = 4;

    // Instruction word written into IF/ID on a flush (sll $0,$0,0)
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Control-field value loaded into ID/EX and EX/MEM on a bubble
    localparam logic [7:0] BUBBLE_CTRL = 8'h00;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and async active-low reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: step on enable, stick at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Produces enables and flush/bubble controls for the PC, IF/ID, ID/EX and
// EX/MEM registers, resolving memory wait, multi-cycle EX ops, load-use
// hazards and taken branch/jump flushes (in that priority order).
// Optional macro HAZARD_PERF_EN builds stall/flush performance counters;
// without it the counter ports read zero.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MC_LAT = 4,
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              idex_memread_i,
    input  logic [REG_AW-1:0] idex_rtaddr_i,
    input  logic [REG_AW-1:0] ifid_rsaddr_i,
    input  logic [REG_AW-1:0] ifid_rtaddr_i,
    input  logic              ifid_uses_rt_i,
    input  logic              branch_taken_i,
    input  logic              jump_i,
    input  logic              mc_start_i,
    input  logic              mem_wait_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_write_o,
    output logic              idex_flush_o,
    output logic              exmem_write_o,
    output logic              exmem_flush_o,
    output logic              mc_busy_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  flush_count_o
);

    // Counter load value: the issue cycle itself is not a busy cycle
    localparam logic [MC_CNT_W-1:0] MC_CNT_INIT = MC_CNT_W'(MC_LAT - 1);

    hz_state_e             state_q;
    hz_state_e             state_d;
    logic [MC_CNT_W-1:0]   cnt_q;
    logic [MC_CNT_W-1:0]   cnt_d;

    logic lu_s;
    logic pc_write_s;
    logic ifid_write_s;
    logic ifid_flush_s;
    logic idex_write_s;
    logic idex_flush_s;
    logic exmem_write_s;
    logic exmem_flush_s;

    // Load-use: load in EX writes a register the IF/ID instruction reads
    always_comb begin
        lu_s = 1'b0;
        if (idex_memread_i && (idex_rtaddr_i != {REG_AW{1'b0}})) begin
            lu_s = (idex_rtaddr_i == ifid_rsaddr_i) ||
                   (ifid_uses_rt_i && (idex_rtaddr_i == ifid_rtaddr_i));
        end else begin
            lu_s = 1'b0;
        end
    end

    // Next state and stage controls, highest-priority condition first
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        ifid_flush_s  = 1'b0;
        idex_write_s  = 1'b1;
        idex_flush_s  = 1'b0;
        exmem_write_s = 1'b1;
        exmem_flush_s = 1'b0;
        if (!rst_i) begin
            // Hold everything and present bubbles while in reset
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            ifid_flush_s  = 1'b1;
            idex_write_s  = 1'b0;
            idex_flush_s  = 1'b1;
            exmem_write_s = 1'b0;
            exmem_flush_s = 1'b1;
        end else if (mem_wait_i) begin
            // Full freeze; state and counter hold, mc_start_i ignored
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_write_s  = 1'b0;
            exmem_write_s = 1'b0;
        end else begin
            case (state_q)
                MC_BUSY: begin
                    // Front end frozen; bubbles drain into EX/MEM
                    pc_write_s    = 1'b0;
                    ifid_write_s  = 1'b0;
                    idex_write_s  = 1'b0;
                    exmem_flush_s = 1'b1;
                    if (cnt_q == {{(MC_CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = RUN;
                        cnt_d   = {MC_CNT_W{1'b0}};
                    end else begin
                        cnt_d   = cnt_q - {{(MC_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RUN: begin
                    if (lu_s) begin
                        // Branch operands not valid yet: no redirect flush
                        pc_write_s   = 1'b0;
                        ifid_write_s = 1'b0;
                        idex_flush_s = 1'b1;
                    end else if (branch_taken_i || jump_i) begin
                        ifid_flush_s = 1'b1;
                    end else begin
                        ifid_flush_s = 1'b0;
                    end
                    if (mc_start_i) begin
                        state_d = MC_BUSY;
                        cnt_d   = MC_CNT_INIT;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = {MC_CNT_W{1'b0}};
                end
            endcase
        end
    end

    // FSM state and multi-cycle down-counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            cnt_q   <= {MC_CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_write_o    = pc_write_s;
    assign ifid_write_o  = ifid_write_s;
    assign ifid_flush_o  = ifid_flush_s;
    assign idex_write_o  = idex_write_s;
    assign idex_flush_o  = idex_flush_s;
    assign exmem_write_o = exmem_write_s;
    assign exmem_flush_o = exmem_flush_s;
    assign mc_busy_o     = (state_q == MC_BUSY);

`ifdef HAZARD_PERF_EN
    logic stall_inc_s;
    logic flush_inc_s;

    assign stall_inc_s = rst_i & ~pc_write_s;
    assign flush_inc_s = rst_i & ifid_flush_s;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_i),
        .inc_i   (stall_inc_s),
        .count_o (stall_cycles_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_i),
        .inc_i   (flush_inc_s),
        .count_o (flush_count_o)
    );
`else
    assign stall_cycles_o = {CNT_W{1'b0}};
    assign flush_count_o  = {CNT_W{1'b0}};
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MC_LAT = 4). Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// Control vector order: {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, busy}
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    localparam logic [7:0] C_RST    = 8'b0010_1010;
    localparam logic [7:0] C_RUN    = 8'b1101_0100;
    localparam logic [7:0] C_LU     = 8'b0001_1100;
    localparam logic [7:0] C_BR     = 8'b1111_0100;
    localparam logic [7:0] C_BUSY   = 8'b0000_0111;
    localparam logic [7:0] C_WAITB  = 8'b0000_0001;
    localparam logic [7:0] C_WAITR  = 8'b0000_0000;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rtaddr_i;
    logic [4:0]       ifid_rsaddr_i;
    logic [4:0]       ifid_rtaddr_i;
    logic             ifid_uses_rt_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             mc_start_i;
    logic             mem_wait_i;
    logic             pc_write_o, ifid_write_o, ifid_flush_o;
    logic             idex_write_o, idex_flush_o;
    logic             exmem_write_o, exmem_flush_o, mc_busy_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [CNT_W-1:0] flush_count_o;
    logic [7:0]       ctl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o,
                  idex_flush_o, exmem_write_o, exmem_flush_o, mc_busy_o};

    hazard_ctrl #(.MC_LAT(4), .REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .idex_memread_i (idex_memread_i),
        .idex_rtaddr_i  (idex_rtaddr_i),
        .ifid_rsaddr_i  (ifid_rsaddr_i),
        .ifid_rtaddr_i  (ifid_rtaddr_i),
        .ifid_uses_rt_i (ifid_uses_rt_i),
        .branch_taken_i (branch_taken_i),
        .jump_i         (jump_i),
        .mc_start_i     (mc_start_i),
        .mem_wait_i     (mem_wait_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_write_o   (idex_write_o),
        .idex_flush_o   (idex_flush_o),
        .exmem_write_o  (exmem_write_o),
        .exmem_flush_o  (exmem_flush_o),
        .mc_busy_o      (mc_busy_o),
        .stall_cycles_o (stall_cycles_o),
        .flush_count_o  (flush_count_o)
    );

    task automatic idle();
        idex_memread_i = 1'b0;
        idex_rtaddr_i  = 5'd0;
        ifid_rsaddr_i  = 5'd0;
        ifid_rtaddr_i  = 5'd0;
        ifid_uses_rt_i = 1'b0;
        branch_taken_i = 1'b0;
        jump_i         = 1'b0;
        mc_start_i     = 1'b0;
        mem_wait_i     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] rt, input logic [4:0] rs);
        idex_memread_i = 1'b1;
        idex_rtaddr_i  = rt;
        ifid_rsaddr_i  = rs;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idex_memread_i = 1'b1; idex_rtaddr_i = 5'd7; ifid_rsaddr_i = 5'd7;
            branch_taken_i = 1'b1; mc_start_i = 1'b1; mem_wait_i = i[0];
            @(negedge clk);
            total++;
            if (ctl !== C_RST) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, ctl, C_RST);
            end
            next_cycle();
        end
        idle();
        rst_i = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin
            bad++;
            $display("FAIL reset_release: got %b expected %b", ctl, C_RUN);
        end
        total++;
        if (stall_cycles_o !== 32'd0 || flush_count_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", stall_cycles_o, flush_count_o);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin
            bad++;
            $display("FAIL reset_idle: got %b expected %b", ctl, C_RUN);
        end
    endtask

    task automatic test_load_use();
        next_cycle();
        set_lu(5'd8, 5'd8);
        @(negedge clk);
        total++;
        if (ctl !== C_LU) begin
            bad++;
            $display("FAIL lu_rs: got %b expected %b", ctl, C_LU);
        end
        next_cycle();
        idle();
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin
            bad++;
            $display("FAIL lu_after: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
        set_lu(5'd0, 5'd0);
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin
            bad++;
            $display("FAIL lu_zero_reg: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
        set_lu(5'd9, 5'd3);
        ifid_rtaddr_i  = 5'd9;
        ifid_uses_rt_i = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin
            bad++;
            $display("FAIL lu_rt_unused: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
        ifid_uses_rt_i = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_LU) begin
            bad++;
            $display("FAIL lu_rt_used: got %b expected %b", ctl, C_LU);
        end
        next_cycle();
        idex_memread_i = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin
            bad++;
            $display("FAIL lu_not_load: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_branch();
        branch_taken_i = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_BR) begin
            bad++;
            $display("FAIL branch_taken: got %b expected %b", ctl, C_BR);
        end
        next_cycle();
        branch_taken_i = 1'b0;
        jump_i         = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_BR) begin
            bad++;
            $display("FAIL jump: got %b expected %b", ctl, C_BR);
        end
        next_cycle();
        branch_taken_i = 1'b1;
        set_lu(5'd12, 5'd12);
        @(negedge clk);
        total++;
        if (ctl !== C_LU) begin
            bad++;
            $display("FAIL branch_with_lu: got %b expected %b", ctl, C_LU);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_multicycle();
        mc_start_i = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin
            bad++;
            $display("FAIL mc_issue: got %b expected %b", ctl, C_RUN);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            // a second start and a branch during busy must be ignored
            mc_start_i     = (i == 0);
            branch_taken_i = (i == 1);
            @(negedge clk);
            total++;
            if (ctl !== C_BUSY) begin
                bad++;
                $display("FAIL mc_busy[%0d]: got %b expected %b", i, ctl, C_BUSY);
            end
        end
        next_cycle();
        idle();
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin
            bad++;
            $display("FAIL mc_done: got %b expected %b", ctl, C_RUN);
        end
        // mem_wait on the 2nd busy cycle stretches busy to 4 cycles
        next_cycle();
        mc_start_i = 1'b1;
        next_cycle();
        mc_start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_wait_i = (i == 1);
            @(negedge clk);
            total++;
            if (ctl !== ((i == 1) ? C_WAITB : C_BUSY)) begin
                bad++;
                $display("FAIL mc_wait[%0d]: got %b expected %b", i, ctl,
                         (i == 1) ? C_WAITB : C_BUSY);
            end
            next_cycle();
        end
        mem_wait_i = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin
            bad++;
            $display("FAIL mc_wait_done: got %b expected %b", ctl, C_RUN);
        end
    endtask

    task automatic test_wait_in_run();
        next_cycle();
        mem_wait_i = 1'b1;
        mc_start_i = 1'b1;
        set_lu(5'd4, 5'd4);
        @(negedge clk);
        total++;
        if (ctl !== C_WAITR) begin
            bad++;
            $display("FAIL wait_run: got %b expected %b", ctl, C_WAITR);
        end
        next_cycle();
        idle();
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin
            bad++;
            $display("FAIL wait_start_ignored: got %b expected %b", ctl, C_RUN);
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        mc_start_i = 1'b1;
        next_cycle();
        mc_start_i = 1'b0;
        @(negedge clk);
        total++;
        if (ctl !== C_BUSY) begin
            bad++;
            $display("FAIL mid_busy1: got %b expected %b", ctl, C_BUSY);
        end
        next_cycle();
        rst_i = 1'b0;
        #1;
        total++;
        if (ctl !== C_RST) begin
            bad++;
            $display("FAIL mid_reset: got %b expected %b", ctl, C_RST);
        end
        next_cycle();
        rst_i = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin
            bad++;
            $display("FAIL mid_release: got %b expected %b", ctl, C_RUN);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (ctl !== C_RUN) begin
            bad++;
            $display("FAIL mid_stays_run: got %b expected %b", ctl, C_RUN);
        end
    endtask

    task automatic test_perf();
        logic [CNT_W-1:0] exp_stall;
        logic [CNT_W-1:0] exp_flush;
`ifdef HAZARD_PERF_EN
        exp_stall = 32'd5;
        exp_flush = 32'd3;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
`endif
        next_cycle();
        rst_i = 1'b0;
        next_cycle();
        rst_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_lu(5'd6, 5'd6);
            next_cycle();
            idle();
            next_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            jump_i = 1'b1;
            next_cycle();
            idle();
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (stall_cycles_o !== exp_stall) begin
            bad++;
            $display("FAIL perf_stall: got %0d expected %0d", stall_cycles_o, exp_stall);
        end
        total++;
        if (flush_count_o !== exp_flush) begin
            bad++;
            $display("FAIL perf_flush: got %0d expected %0d", flush_count_o, exp_flush);
        end
    endtask

    initial begin
        idle();
        rst_i = 1'b0;
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_multicycle();
        test_wait_in_run();
        test_reset_mid();
        test_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_ctrl
